// File: rtl/axi_xbar_if.sv
// AXI-lite channel bundle (AR/R/AW/W/B) shared by the arbiter side and both slaves.
// master modport: issues addresses/data and takes responses; slave modport: the reverse.
interface axi_xbar_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_xbar.sv
// 1-master / 2-slave AXI-lite decoding crossbar, one transaction in flight.
// Target is decoded and registered when the address is accepted; responses pass
// back combinationally. Optional macro XBAR_DECERR_EN: unmapped addresses are
// answered locally with DECERR instead of being sent to main memory.
module axi_xbar #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_MASK = 32'hf800_0000,
    parameter logic [ADDR_W-1:0] DEV_BASE = 32'ha000_0000,
    parameter logic [ADDR_W-1:0] DEV_MASK = 32'hf000_0000
) (
    input  logic        clk,
    input  logic        rst,
    axi_xbar_if.slave   m,
    axi_xbar_if.master  mem,
    axi_xbar_if.master  dev
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP} state_e;
    typedef enum logic [1:0] {TGT_MEM, TGT_DEV, TGT_ERR} tgt_e;

`ifdef XBAR_DECERR_EN
    localparam tgt_e UNMAPPED_TGT = TGT_ERR;
`else
    localparam tgt_e UNMAPPED_TGT = TGT_MEM;
`endif

    // Device window wins when both windows match.
    function automatic tgt_e decode(input logic [ADDR_W-1:0] a);
        if ((a & DEV_MASK) == DEV_BASE) return TGT_DEV;
        if ((a & MEM_MASK) == MEM_BASE) return TGT_MEM;
        return UNMAPPED_TGT;
    endfunction

    state_e            state_q, state_d;
    tgt_e              tgt_q, tgt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    // Selected-slave view: valids/readies toward the target and its returned signals.
    logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic              s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp, s_bresp;
    logic              wr_ok;

    // Return-path mux; the ERR target answers locally with DECERR.
    always_comb begin
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
        case (tgt_q)
            TGT_DEV: begin
                s_arready = dev.arready; s_rdata = dev.rdata; s_rresp = dev.rresp;
                s_rvalid = dev.rvalid; s_awready = dev.awready; s_wready = dev.wready;
                s_bresp = dev.bresp; s_bvalid = dev.bvalid;
            end
            TGT_ERR: begin
                s_rvalid = 1'b1; s_rresp = 2'b11; s_bvalid = 1'b1; s_bresp = 2'b11;
            end
            default: begin
                s_arready = mem.arready; s_rdata = mem.rdata; s_rresp = mem.rresp;
                s_rvalid = mem.rvalid; s_awready = mem.awready; s_wready = mem.wready;
                s_bresp = mem.bresp; s_bvalid = mem.bvalid;
            end
        endcase
    end

    // Transaction FSM: next state, captured registers and handshake outputs.
    always_comb begin
        state_d = state_q; tgt_d = tgt_q; addr_d = addr_q; wdata_d = wdata_q;
        aw_done_d = aw_done_q; w_done_d = w_done_q;
        m.arready = 1'b0; m.awready = 1'b0; m.wready = 1'b0;
        m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00;
        m.bvalid = 1'b0; m.bresp = 2'b00;
        s_arvalid = 1'b0; s_rready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        // Writes only go when no read competes and both AW and W are present.
        wr_ok = !m.arvalid && m.awvalid && m.wvalid;
        case (state_q)
            IDLE: begin
                m.arready = rst;
                m.awready = wr_ok && rst;
                m.wready  = wr_ok && rst;
                if (m.arvalid) begin
                    addr_d  = m.araddr;
                    tgt_d   = decode(m.araddr);
                    state_d = (decode(m.araddr) == TGT_ERR) ? RD_RESP : RD_REQ;
                end else if (wr_ok) begin
                    addr_d    = m.awaddr;
                    wdata_d   = m.wdata;
                    tgt_d     = decode(m.awaddr);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (decode(m.awaddr) == TGT_ERR) ? WR_RESP : WR_REQ;
                end
            end
            RD_REQ: begin
                s_arvalid = 1'b1;
                if (s_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                m.rvalid = s_rvalid; m.rdata = s_rdata; m.rresp = s_rresp;
                s_rready = m.rready;
                if (s_rvalid && m.rready) state_d = IDLE;
            end
            WR_REQ: begin
                s_awvalid = !aw_done_q;
                s_wvalid  = !w_done_q;
                aw_done_d = aw_done_q || (s_awvalid && s_awready);
                w_done_d  = w_done_q || (s_wvalid && s_wready);
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                m.bvalid = s_bvalid; m.bresp = s_bresp;
                s_bready = m.bready;
                if (s_bvalid && m.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE; tgt_q <= TGT_MEM; addr_q <= '0; wdata_q <= '0;
            aw_done_q <= 1'b0; w_done_q <= 1'b0;
        end else begin
            state_q <= state_d; tgt_q <= tgt_d; addr_q <= addr_d; wdata_q <= wdata_d;
            aw_done_q <= aw_done_d; w_done_q <= w_done_d;
        end
    end

    // Only the selected slave ever sees a valid/ready; addr/data fan out to both.
    assign mem.arvalid = s_arvalid && (tgt_q == TGT_MEM);
    assign mem.rready  = s_rready  && (tgt_q == TGT_MEM);
    assign mem.awvalid = s_awvalid && (tgt_q == TGT_MEM);
    assign mem.wvalid  = s_wvalid  && (tgt_q == TGT_MEM);
    assign mem.bready  = s_bready  && (tgt_q == TGT_MEM);
    assign dev.arvalid = s_arvalid && (tgt_q == TGT_DEV);
    assign dev.rready  = s_rready  && (tgt_q == TGT_DEV);
    assign dev.awvalid = s_awvalid && (tgt_q == TGT_DEV);
    assign dev.wvalid  = s_wvalid  && (tgt_q == TGT_DEV);
    assign dev.bready  = s_bready  && (tgt_q == TGT_DEV);
    assign mem.araddr  = addr_q;
    assign mem.awaddr  = addr_q;
    assign mem.wdata   = wdata_q;
    assign dev.araddr  = addr_q;
    assign dev.awaddr  = addr_q;
    assign dev.wdata   = wdata_q;
endmodule
